// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator: byte stream in, sclk/mosi/cs out, miso sampled into rxData.
// Latency: cs/mosi one cycle after accept; rxValid 1+16*CLK_DIV cycles after accept.
// Backpressure: txReady only in IDLE/WAIT; cs held low between bytes until a txLast byte.
//
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   txData/txValid/txLast/txReady - host byte stream (accept on txValid && txReady)
//   rxData/rxValid    - received byte, rxValid pulses one cycle when rxData updates
//   busy              - high whenever the controller is not IDLE
//   sclk/mosi/miso/cs - SPI pins (mode 0, MSB first, cs active low)
// Build option: SPI_MASTER_LOOPBACK_EN routes internal mosi into the rx shifter.

module spi_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] txData,
    input  logic       txValid,
    input  logic       txLast,
    output logic       txReady,
    output logic [7:0] rxData,
    output logic       rxValid,
    output logic       busy,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs
);

    localparam int DW = $clog2(CLK_DIV + 1);
    // Counter runs RELOAD..0, so each phase lasts exactly CLK_DIV cycles.
    localparam logic [DW-1:0] RELOAD = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_vld_q, rx_vld_d;
    logic          last_q, last_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          cs_q, cs_d;
    logic          rx_in;
    logic          accept;
    logic          div_zero;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso;
    assign rx_in       = mosi_q;
`else
    assign rx_in = miso;
`endif

    assign txReady  = !reset && ((state_q == S_IDLE) || (state_q == S_WAIT));
    assign accept   = txValid && txReady;
    assign div_zero = (div_cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        rx_vld_d  = 1'b0;
        last_d    = last_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_d      = cs_q;

        case (state_q)
            S_IDLE, S_WAIT: begin
                if (accept) begin
                    tx_sh_d   = txData;
                    last_d    = txLast;
                    mosi_d    = txData[7];
                    cs_d      = 1'b0;
                    sclk_d    = 1'b0;
                    div_cnt_d = RELOAD;
                    bit_cnt_d = 4'd0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (div_zero) begin
                    div_cnt_d = RELOAD;
                    sclk_d    = !sclk_q;
                    if (!sclk_q) begin
                        // Rising edge: capture the incoming bit.
                        rx_sh_d = {rx_sh_q[6:0], rx_in};
                    end else begin
                        // Falling edge: bit_cnt counts completed bits.
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            rx_data_d = rx_sh_q;
                            rx_vld_d  = 1'b1;
                            state_d   = last_q ? S_HOLD : S_WAIT;
                        end else begin
                            tx_sh_d = tx_sh_q << 1;
                            mosi_d  = tx_sh_q[6];
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q - DW'(1);
                end
            end
            S_HOLD: begin
                if (div_zero) begin
                    cs_d      = 1'b1;
                    div_cnt_d = RELOAD;
                    state_d   = S_GAP;
                end else begin
                    div_cnt_d = div_cnt_q - DW'(1);
                end
            end
            S_GAP: begin
                if (div_zero) begin
                    state_d = S_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q - DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= 4'd0;
            tx_sh_q   <= 8'h00;
            rx_sh_q   <= 8'h00;
            rx_data_q <= 8'h00;
            rx_vld_q  <= 1'b0;
            last_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            rx_vld_q  <= rx_vld_d;
            last_q    <= last_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_q      <= cs_d;
        end
    end

    assign rxData  = rx_data_q;
    assign rxValid = rx_vld_q;
    assign busy    = (state_q != S_IDLE);
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs      = cs_q;

endmodule
